// File: rtl/median_filter_pkg.sv
// rtl/median_filter_pkg.sv - shared states, window constants and default geometry for the binary median filter
package median_filter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        BORDER,
        DONE
    } state_t;

    localparam int WIN_SIZE       = 9;
    localparam int MAJORITY       = 5;
    localparam int COUNT_W        = 4;

    localparam int DEFAULT_IMG_W  = 256;
    localparam int DEFAULT_IMG_H  = 256;
    localparam int DEFAULT_ADDR_W = 8;

endpackage

// File: rtl/median_accumulator.sv
// rtl/median_accumulator.sv - counts ones across a 3x3 window and reports the majority bit
module median_accumulator
    import median_filter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               sample_valid,
    input  logic               data,
    output logic [COUNT_W-1:0] count,
    output logic               majority
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (sample_valid && data) begin
            count <= count + 1'b1;
        end
    end

    assign majority = (count >= COUNT_W'(MAJORITY));

endmodule

// File: rtl/median_filter_binary.sv
// rtl/median_filter_binary.sv - 3x3 binary median filter FSM and address generation; FILTER_BORDER_CLEAR_EN adds border clearing
module median_filter_binary
    import median_filter_pkg::*;
#(
    parameter int IMG_W  = DEFAULT_IMG_W,
    parameter int IMG_H  = DEFAULT_IMG_H,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dataIn,
    input  logic              start,
    output logic [ADDR_W-1:0] xAddressOut,
    output logic [ADDR_W-1:0] yAddressOut,
    output logic [ADDR_W-1:0] xMedianAddress,
    output logic [ADDR_W-1:0] yMedianAddress,
    output logic              filterDone,
    output logic              filterReady,
    output logic              dataOut,
    output logic              writeEnable
);

    localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
    localparam logic [3:0]        K_LAST = 4'(WIN_SIZE - 1);

`ifdef FILTER_BORDER_CLEAR_EN
    localparam logic [ADDR_W-1:0] X_MAX = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] Y_MAX = ADDR_W'(IMG_H - 1);
    localparam state_t AFTER_INTERIOR   = BORDER;
`else
    localparam state_t AFTER_INTERIOR   = DONE;
`endif

    state_t              state, next_state;
    logic [ADDR_W-1:0]   cx, cy;
    logic [3:0]          k;
    logic [1:0]          col;
    logic                read_valid;
    logic                last_centre;
    logic                border_last;
    logic [COUNT_W-1:0]  ones;
    logic                majority;

    assign last_centre = (cx == X_LAST) && (cy == Y_LAST);

`ifdef FILTER_BORDER_CLEAR_EN
    assign border_last = (xMedianAddress == X_MAX) && (yMedianAddress == Y_MAX);
`else
    assign border_last = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (start) next_state = READ;
            READ:   if (k == K_LAST) next_state = WAIT;
            WAIT:   next_state = WRITE;
            WRITE:  next_state = last_centre ? AFTER_INTERIOR : READ;
            BORDER: if (border_last) next_state = DONE;
            DONE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Read addresses step with the window index so they are valid in the same cycle as the READ state.
    always_ff @(posedge clk) begin
        if (reset) begin
            cx             <= '0;
            cy             <= '0;
            k              <= '0;
            col            <= '0;
            xAddressOut    <= '0;
            yAddressOut    <= '0;
            xMedianAddress <= '0;
            yMedianAddress <= '0;
            read_valid     <= 1'b0;
        end else begin
            read_valid <= (state == READ);
            case (state)
                IDLE: begin
                    if (start) begin
                        cx          <= ONE;
                        cy          <= ONE;
                        k           <= '0;
                        col         <= '0;
                        xAddressOut <= '0;
                        yAddressOut <= '0;
                    end
                end
                READ: begin
                    if (k != K_LAST) begin
                        k <= k + 1'b1;
                        if (col == 2'd2) begin
                            col         <= '0;
                            xAddressOut <= xAddressOut - ADDR_W'(2);
                            yAddressOut <= yAddressOut + ONE;
                        end else begin
                            col         <= col + 1'b1;
                            xAddressOut <= xAddressOut + ONE;
                        end
                    end
                end
                WAIT: begin
                    xMedianAddress <= cx;
                    yMedianAddress <= cy;
                end
                WRITE: begin
                    k   <= '0;
                    col <= '0;
                    if (last_centre) begin
`ifdef FILTER_BORDER_CLEAR_EN
                        xMedianAddress <= '0;
                        yMedianAddress <= '0;
`endif
                    end else if (cx == X_LAST) begin
                        cx          <= ONE;
                        cy          <= cy + ONE;
                        xAddressOut <= '0;
                        yAddressOut <= cy;
                    end else begin
                        cx          <= cx + ONE;
                        xAddressOut <= cx;
                        yAddressOut <= cy - ONE;
                    end
                end
`ifdef FILTER_BORDER_CLEAR_EN
                // Middle rows only have two border pixels, so jump straight to the right edge.
                BORDER: begin
                    if (!border_last) begin
                        if (xMedianAddress == X_MAX) begin
                            xMedianAddress <= '0;
                            yMedianAddress <= yMedianAddress + ONE;
                        end else if (yMedianAddress == '0 || yMedianAddress == Y_MAX) begin
                            xMedianAddress <= xMedianAddress + ONE;
                        end else begin
                            xMedianAddress <= X_MAX;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    median_accumulator u_acc (
        .clk          (clk),
        .reset        (reset),
        .clear        ((state == IDLE) || (state == WRITE)),
        .sample_valid (read_valid),
        .data         (dataIn),
        .count        (ones),
        .majority     (majority)
    );

    assign filterReady = (state == IDLE);
    assign filterDone  = (state == DONE);
    assign writeEnable = (state == WRITE) || (state == BORDER);
    assign dataOut     = (state == WRITE) && majority;

endmodule

// File: tb/tb_median_filter_binary.sv
// tb/tb_median_filter_binary.sv - self-checking bench for median_filter_binary on a 5x5 frame
module tb_median_filter_binary;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int AW = 8;
    localparam int NPIX = (W - 2) * (H - 2);
`ifdef FILTER_BORDER_CLEAR_EN
    localparam int NBORDER = 2 * W + 2 * (H - 2);
`else
    localparam int NBORDER = 0;
`endif
    localparam int DONE_CYC = 11 * NPIX + 1 + NBORDER;

    typedef struct {
        logic [24:0] img;
        logic [8:0]  exp_bits;
    } vec_t;

    typedef struct {
        int   x;
        int   y;
        logic d;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic dataIn = 1'b0;
    logic start = 1'b0;
    logic [AW-1:0] xAddressOut, yAddressOut, xMedianAddress, yMedianAddress;
    logic filterDone, filterReady, dataOut, writeEnable;

    logic [24:0] img = '0;
    wr_t wq[$];
    int checks = 0;
    int errors = 0;

    median_filter_binary #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .dataIn         (dataIn),
        .start          (start),
        .xAddressOut    (xAddressOut),
        .yAddressOut    (yAddressOut),
        .xMedianAddress (xMedianAddress),
        .yMedianAddress (yMedianAddress),
        .filterDone     (filterDone),
        .filterReady    (filterReady),
        .dataOut        (dataOut),
        .writeEnable    (writeEnable)
    );

    always #5 clk = ~clk;

    function automatic logic ram_rd(input int x, input int y);
        if (x < W && y < H) return img[y * W + x];
        return 1'b0;
    endfunction

    always @(posedge clk) dataIn <= ram_rd(int'(xAddressOut), int'(yAddressOut));

    always @(negedge clk) begin
        if (writeEnable) wq.push_back('{int'(xMedianAddress), int'(yMedianAddress), dataOut});
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: count ones in every 3x3 window and take the majority.
    function automatic logic [8:0] model(input logic [24:0] im);
        logic [8:0] r = '0;
        for (int cy = 1; cy <= H - 2; cy++)
            for (int cx = 1; cx <= W - 2; cx++) begin
                int cnt = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        cnt += int'(im[(cy + dy) * W + cx + dx]);
                r[(cy - 1) * (W - 2) + cx - 1] = (cnt >= 5);
            end
        return r;
    endfunction

    task automatic run_frame(input logic [24:0] im, input logic [8:0] exp_bits,
                             input int mid, input bit done_start);
        wr_t exp_q[$];
        int done_cyc = 0;
        img = im;
        @(negedge clk);
        wq.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= DONE_CYC + 50; c++) begin
            if (c <= 9)
                check("rd_addr", int'(xAddressOut) * 256 + int'(yAddressOut),
                      ((c - 1) % 3) * 256 + (c - 1) / 3);
            if (c == 1) check("ready_busy", int'(filterReady), 0);
            if (c == 10) check("wait_no_we", int'(writeEnable), 0);
            if (c == 11)
                check("first_wr", int'(writeEnable) * 65536 + int'(xMedianAddress) * 256 + int'(yMedianAddress),
                      65536 + 256 + 1);
            if (filterDone) begin
                done_cyc = c;
                break;
            end
            start = (c == mid);
            @(negedge clk);
        end
        start = 1'b0;
        check("done_cycle", done_cyc, DONE_CYC);
        start = done_start;
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", int'(filterDone), 0);
        check("ready_after_done", int'(filterReady), 1);
        @(negedge clk);
        check("ready_idle", int'(filterReady), 1);

        for (int cy = 1; cy <= H - 2; cy++)
            for (int cx = 1; cx <= W - 2; cx++)
                exp_q.push_back('{cx, cy, exp_bits[(cy - 1) * (W - 2) + cx - 1]});
`ifdef FILTER_BORDER_CLEAR_EN
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (x == 0 || y == 0 || x == W - 1 || y == H - 1) exp_q.push_back('{x, y, 1'b0});
`endif
        check("write_count", wq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
            check($sformatf("write[%0d] x/y/d", i),
                  wq[i].x * 65536 + wq[i].y * 256 + int'(wq[i].d),
                  exp_q[i].x * 65536 + exp_q[i].y * 256 + int'(exp_q[i].d));
    endtask

    initial begin
        vec_t vecs[6];
        bit saw_done;
        vecs[0] = '{25'h1FFFFFF, 9'h1FF};
        vecs[1] = '{25'h0000000, 9'h000};
        vecs[2] = '{25'h0001000, 9'h000};
        vecs[3] = '{25'h000212F, 9'h002};
        vecs[4] = '{25'h1555555, 9'h155};
        vecs[5] = '{25'h1FFEFFF, 9'h1FF};

        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", int'(filterReady), 1);
        check("rst_we", int'(writeEnable), 0);
        check("rst_done", int'(filterDone), 0);
        check("rst_addr", int'({xAddressOut, yAddressOut, xMedianAddress, yMedianAddress}), 0);
        check("rst_dout", int'(dataOut), 0);
        reset = 1'b0;
        start = 1'b0;
        wq.delete();
        repeat (5) @(negedge clk);
        check("post_rst_ready", int'(filterReady), 1);
        check("post_rst_writes", wq.size(), 0);

        for (int i = 0; i < 6; i++) run_frame(vecs[i].img, vecs[i].exp_bits, 0, (i == 1));

        run_frame(25'h1FFFFFF, 9'h1FF, 40, 1'b0);

        img = 25'h1FFFFFF;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        wq.delete();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready", int'(filterReady), 1);
        check("abort_we", int'(writeEnable), 0);
        check("abort_addr", int'({xAddressOut, yAddressOut, xMedianAddress, yMedianAddress}), 0);
        saw_done = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (filterDone) saw_done = 1'b1;
        end
        check("abort_no_done", int'(saw_done), 0);
        check("abort_no_writes", wq.size(), 0);
        run_frame(25'h0FFFFFE, model(25'h0FFFFFE), 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            logic [24:0] im;
            case (r % 3)
                0: im = 25'($urandom);
                1: im = 25'($urandom & $urandom);
                default: im = 25'($urandom | $urandom);
            endcase
            run_frame(im, model(im), (r == 3) ? 57 : 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/median_filter_binary.md
Name: median_filter_binary

Overview:
- 3x3 median filter for a 1-bit image held in an external frame buffer with synchronous read.
- On a `start` pulse it scans every interior pixel of the source image.
- For each interior pixel it reads the 9-pixel window and writes the majority bit to an output buffer.
- Sits between the source image RAM (read port) and the result RAM (write port).

Parameters:
- IMG_W, 256, image width in pixels (3..256).
- IMG_H, 256, image height in pixels (3..256).
- ADDR_W, 8, width of every address port; must satisfy 2^ADDR_W >= max(IMG_W, IMG_H).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- dataIn  in  1  source pixel; valid exactly 1 cycle after the read address is presented.
- start  in  1  1-cycle request to filter one frame; sampled only in IDLE.
- xAddressOut  out  ADDR_W  source read column.
- yAddressOut  out  ADDR_W  source read row.
- xMedianAddress  out  ADDR_W  result write column.
- yMedianAddress  out  ADDR_W  result write row.
- filterDone  out  1  1-cycle pulse when the frame is complete.
- filterReady  out  1  high while IDLE (accepting start).
- dataOut  out  1  filtered pixel; qualified by writeEnable.
- writeEnable  out  1  1-cycle result write strobe.

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: all addresses 0, dataOut 0, writeEnable 0, filterDone 0, filterReady 1, state IDLE, counters 0.
- Reset asserted mid-frame aborts the frame. No write and no done pulse are produced afterwards.
- States and transitions:
  - IDLE: filterReady=1. start=1 -> READ, with centre (cx,cy)=(1,1) and window index k=0.
  - READ: 9 cycles, k=0..8. Outputs x=cx-1+(k%3), y=cy-1+(k/3), i.e. row-major from the top-left neighbour.
  - WAIT: 1 cycle to absorb the last read latency.
  - WRITE: 1 cycle. writeEnable=1, xMedianAddress=cx, yMedianAddress=cy, dataOut=(ones>=5).
  - After WRITE: advance cx; at cx=IMG_W-2 wrap cx to 1 and increment cy. After centre (IMG_W-2, IMG_H-2) go to DONE, otherwise go to READ.
  - DONE: filterDone=1 for 1 cycle -> IDLE.
- Accumulation:
  - Each dataIn sample arriving 1 cycle after a READ address adds to a 4-bit ones-count (0..9).
  - The count is cleared when entering READ for a new centre.
- Timing:
  - Per pixel: exactly 11 cycles (9 READ + WAIT + WRITE).
  - Frame: start sampled -> filterDone = 11*(IMG_W-2)*(IMG_H-2)+1 cycles.
- Border handling: border rows and columns are never written (default build).
- Idle outputs: in IDLE and DONE, writeEnable=0. Address outputs hold their last values.
- start while busy is ignored; no queueing.
- start in the same cycle as reset: reset wins.
- start in the cycle DONE returns to IDLE is ignored, because filterReady was 0 when start was sampled.

Optional Feature:
- Macro: FILTER_BORDER_CLEAR_EN.
- Defined:
  - After the last interior write, add a BORDER state that writes dataOut=0 to every border pixel, one per cycle.
  - Scan order is row-major over the full frame, skipping interior pixels.
  - writeEnable=1 on each border write.
  - filterDone follows the last border write.
  - Adds 2*IMG_W+2*(IMG_H-2) cycles.
- Undefined: no BORDER state; border locations are untouched.

Decomposition:
- Package median_filter_pkg holds:
  - state enum (IDLE, READ, WAIT, WRITE, BORDER, DONE);
  - WIN_SIZE=9;
  - MAJORITY=5;
  - default geometry constants.
- One sub-module, median_accumulator:
  - takes the sample-valid strobe, dataIn and clear;
  - provides the 4-bit count and the majority bit.
- Top level holds the FSM and the address counters.

Test Plan:
- Reset/idle: hold reset 3 cycles -> filterReady=1, writeEnable=0, filterDone=0, all addresses 0. start during reset -> no activity.
- All-ones image, IMG_W=IMG_H=5: pulse start -> 9 writes, each dataOut=1, at centres (1,1)..(3,3) row-major. filterDone exactly 100 cycles after start is sampled.
- Address sequence: first centre reads (0,0),(1,0),(2,0),(0,1),(1,1),(2,1),(0,2),(1,2),(2,2). Then WAIT, then write at (1,1) with writeEnable high 1 cycle.
- Majority threshold: model RAM so window 1 has 4 ones -> dataOut=0, and window 2 has 5 ones -> dataOut=1. A single isolated 1 in a zero field is removed.
- Busy/abort: start pulses mid-frame -> ignored, frame length unchanged. Reset mid-frame -> immediate IDLE. A new start then restarts at centre (1,1).
- FILTER_BORDER_CLEAR_EN, 5x5 frame: 9 interior writes, then 16 border writes with dataOut=0 in row-major order, then filterDone.
